// File: rtl/pipelined_n_bit_subtractor_if.sv
// Streaming operand/result bundle for the chunked pipelined subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface pipelined_n_bit_subtractor_if #(
   parameter int N = 16
);
   logic         enable;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         borin;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] D;
   logic         borout;
   logic         ovf;
   logic         zero;

   modport master (
      output enable, in_valid, a, b, borin, out_ready,
      input  in_ready, out_valid, D, borout, ovf, zero
   );

   modport slave (
      input  enable, in_valid, a, b, borin, out_ready,
      output in_ready, out_valid, D, borout, ovf, zero
   );
endinterface

// File: rtl/pipelined_n_bit_subtractor.sv
// D = a - b - borin resolved one C-bit chunk per stage, borrow registered between
// stages; a single global advance stalls the whole pipe when the result is not taken.
module pipelined_n_bit_subtractor #(
   parameter int N = 16,
   parameter int S = 4
) (
   input logic                         clk,
   input logic                         rst_n,
   pipelined_n_bit_subtractor_if.slave bus
);
   localparam int C = N / S;
   localparam int L = S - 1;

   if (S < 1 || (N % S) != 0) begin : g_param_check
      $error("pipelined_n_bit_subtractor: N (%0d) must be a multiple of S (%0d)", N, S);
   end

   logic         advance;
   logic [S-1:0] vld;
   logic [S:0]   vld_in;
   logic [N-1:0] diff_q;
   logic         borout_q;
   logic         ovf_q;
   logic         zero_q;

   assign advance = !vld[S-1] | bus.out_ready;
   assign vld_in  = {vld, bus.in_valid};

   // Stage k sees only the unresolved chunks (width W) plus the resolved low chunks,
   // so operand registers shrink by C bits per stage and the top chunk keeps the signs.
   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int W = N - k * C;

      logic [W-1:0]       a_in;
      logic [W-1:0]       b_in;
      logic               bw_in;
      logic [C:0]         diff;
      logic [(k+1)*C-1:0] d_out;

      if (k == 0) begin : g_src
         assign a_in  = bus.enable ? bus.a : '0;
         assign b_in  = bus.enable ? bus.b : '0;
         assign bw_in = bus.borin & bus.enable;
         assign d_out = diff[C-1:0];
      end else begin : g_src
         assign a_in  = g_stage[k-1].g_reg.a_q;
         assign b_in  = g_stage[k-1].g_reg.b_q;
         assign bw_in = g_stage[k-1].g_reg.bw_q;
         assign d_out = {diff[C-1:0], g_stage[k-1].g_reg.d_q};
      end

      assign diff = {1'b0, a_in[C-1:0]} - {1'b0, b_in[C-1:0]} - (C+1)'(bw_in);

      if (k < S - 1) begin : g_reg
         logic [W-C-1:0]     a_q;
         logic [W-C-1:0]     b_q;
         logic [(k+1)*C-1:0] d_q;
         logic               bw_q;

         // NOTE: datapath registers carry no reset; the valid bits alone decide
         // whether a slot means anything, so stale data here is never observed.
         always_ff @(posedge clk) begin
            if (advance) begin
               a_q  <= a_in[W-1:C];
               b_q  <= b_in[W-1:C];
               d_q  <= d_out;
               bw_q <= diff[C];
            end
         end
      end
   end

   logic [N-1:0] last_d;
   logic         last_bw;
   logic         last_sa;
   logic         last_sb;

   assign last_d  = g_stage[L].d_out;
   assign last_bw = g_stage[L].diff[C];
   assign last_sa = g_stage[L].a_in[C-1];
   assign last_sb = g_stage[L].b_in[C-1];

   // NOTE: state is updated with non-blocking assignments so every register in the
   // pipe samples pre-edge values and the shift happens as one simultaneous step.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld      <= '0;
         diff_q   <= '0;
         borout_q <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else if (advance) begin
         vld <= vld_in[S-1:0];
         // Result registers only move on a real op, so they hold across bubbles.
         if (vld_in[S-1]) begin
            diff_q   <= last_d;
            borout_q <= last_bw;
            ovf_q    <= (last_sa != last_sb) & (last_d[N-1] != last_sa);
            zero_q   <= (last_d == '0);
         end
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = vld[S-1];
   assign bus.D         = diff_q;
   assign bus.borout    = borout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule
